// File: rtl/uart_rx_cmd.sv
// UART receiver with a small command decoder driving four LEDs.
// The line is synchronised, framed by a mid-bit sampling FSM, and good
// frames update the word and LED outputs with a one-cycle data_valid pulse.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | line idle; waiting for rxs low (only once rxs was seen high)
//   S_START | timing to the middle of the start bit, rejecting glitches
//   S_DATA  | sampling DATA_BITS data bits, LSB first, one per bit period
//   S_PAR   | sampling the parity bit and recording a mismatch
//   S_STOP  | sampling the stop bit and reporting the frame outcome
module uart_rx_cmd #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0
) (
  input  logic                 clk_50,
  input  logic                 rst,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic [3:0]           led
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int LB = (DATA_BITS < 8) ? DATA_BITS : 8;
  localparam logic [CW-1:0] HALF_C   = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_C   = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    LAST_IDX = 4'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_err_q, par_err_d;
  logic                 armed_q, armed_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [3:0]           led_q, led_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_q, perr_d;

  logic                 rxs;
  logic [7:0]           low8;
  logic [3:0]           cmd_led;
  logic                 par_exp;

  assign rxs     = sync2_q;
  assign low8    = 8'(shift_q[LB-1:0]);
  assign par_exp = (PARITY == 1);

  // Command decode of the word currently in the shift register
  always_comb begin
    case (low8)
      8'h77:   cmd_led = 4'b1000;
      8'h61:   cmd_led = 4'b0100;
      8'h73:   cmd_led = 4'b0010;
      8'h64:   cmd_led = 4'b0001;
      default: cmd_led = 4'b0000;
    endcase
  end

  // Synchroniser, frame FSM, bit timer and output register next-state logic
  always_comb begin
    sync1_d   = rx_in;
    sync2_d   = sync1_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    par_err_d = par_err_q;
    armed_d   = armed_q;
    data_d    = data_q;
    led_d     = led_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    perr_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (rxs) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d   = S_START;
          par_err_d = 1'b0;
        end
      end
      S_START: begin
        if (cnt_q == HALF_C) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rxs ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == FULL_C) begin
          cnt_d   = '0;
          shift_d = {rxs, shift_q[DATA_BITS-1:1]};
          if (idx_q == LAST_IDX) begin
            state_d = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PAR: begin
        if (cnt_q == FULL_C) begin
          cnt_d     = '0;
          par_err_d = ((^shift_q) ^ rxs) != par_exp;
          state_d   = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == FULL_C) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (!rxs) begin
            // A held-low line must rise before another frame may start
            ferr_d  = 1'b1;
            armed_d = 1'b0;
          end else if (par_err_q && (PARITY != 0)) begin
            perr_d = 1'b1;
          end else begin
            valid_d = 1'b1;
            data_d  = shift_q;
            led_d   = cmd_led;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_50) begin
    if (rst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      par_err_q <= 1'b0;
      armed_q   <= 1'b1;
      data_q    <= '0;
      led_q     <= 4'b0000;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      par_err_q <= par_err_d;
      armed_q   <= armed_d;
      data_q    <= data_d;
      led_q     <= led_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      perr_q    <= perr_d;
    end
  end

  assign data_out   = data_q;
  assign led        = led_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign parity_err = perr_q;

endmodule

// File: tb/tb_uart_rx_cmd.sv
// Bench for uart_rx_cmd: instance A uses default timing (8N1, 434 clk/bit),
// instance B uses 16 clk/bit with even parity for parity and random frames.
// A frame-level model predicts each outcome, its timing window, and the
// resulting word/LED state; a compare process checks every cycle.
module tb_uart_rx_cmd;

  typedef struct {
    int         kind;   // 0 good, 1 frame error, 2 parity error
    logic [7:0] word;
    longint     tmin;
    longint     tmax;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_a = 1'b1, rst_b = 1'b1;
  logic       rx_a = 1'b1, rx_b = 1'b1;
  logic [7:0] dout_a, dout_b;
  logic       dv_a, fe_a, pe_a, dv_b, fe_b, pe_b;
  logic [3:0] led_a, led_b;

  int     checks = 0;
  int     failures = 0;
  longint cyc = 0;
  bit     chk_en = 1'b0;

  ev_t        q0[$];
  ev_t        q1[$];
  logic [7:0] exp_dat[2];
  logic [3:0] exp_led[2];
  int         cnt_v[2], cnt_f[2], cnt_p[2];
  longint     last_v[2], prev_v[2];

  uart_rx_cmd #(.CLKS_PER_BIT(434), .DATA_BITS(8), .PARITY(0)) dut_a (
    .clk_50(clk), .rst(rst_a), .rx_in(rx_a), .data_out(dout_a),
    .data_valid(dv_a), .frame_err(fe_a), .parity_err(pe_a), .led(led_a));

  uart_rx_cmd #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(2)) dut_b (
    .clk_50(clk), .rst(rst_b), .rx_in(rx_b), .data_out(dout_b),
    .data_valid(dv_b), .frame_err(fe_b), .parity_err(pe_b), .led(led_b));

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] cmd_led(input logic [7:0] w);
    case (w)
      8'h77:   return 4'b1000;
      8'h61:   return 4'b0100;
      8'h73:   return 4'b0010;
      8'h64:   return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic int cpb(input int i);
    return (i == 0) ? 434 : 16;
  endfunction

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %0h, expected %0h at cycle %0d", nm, act, req, cyc);
    end
  endtask

  task automatic handle(input int i, input logic v, input logic fe, input logic pe,
                        input logic [7:0] d, input logic [3:0] l);
    ev_t e;
    bit  have;
    int  n;
    have = 1'b1;
    while (have) begin
      have = 1'b0;
      if (i == 0 && q0.size() > 0 && q0[0].tmax < cyc) begin e = q0.pop_front(); have = 1'b1; end
      if (i == 1 && q1.size() > 0 && q1[0].tmax < cyc) begin e = q1.pop_front(); have = 1'b1; end
      if (have) chk($sformatf("missing_event_inst%0d", i), 0, 1);
    end
    n = int'(v) + int'(fe) + int'(pe);
    if (n > 1) chk($sformatf("multi_flag_inst%0d", i), n, 1);
    if (n >= 1) begin
      have = 1'b0;
      if (i == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      if (i == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      if (!have) begin
        chk($sformatf("unexpected_pulse_inst%0d", i), 1, 0);
      end else begin
        chk($sformatf("pulse_kind_inst%0d", i), fe ? 1 : (pe ? 2 : 0), e.kind);
        chk($sformatf("pulse_time_in_window_inst%0d", i),
            (cyc >= e.tmin && cyc <= e.tmax) ? 1 : 0, 1);
        if (e.kind == 0) begin
          exp_dat[i] = e.word;
          exp_led[i] = cmd_led(e.word);
        end
      end
      if (v) begin cnt_v[i]++; prev_v[i] = last_v[i]; last_v[i] = cyc; end
      if (fe) cnt_f[i]++;
      if (pe) cnt_p[i]++;
    end
    chk($sformatf("data_out_inst%0d", i), d, exp_dat[i]);
    chk($sformatf("led_inst%0d", i), l, exp_led[i]);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      handle(0, dv_a, fe_a, pe_a, dout_a, led_a);
      handle(1, dv_b, fe_b, pe_b, dout_b, led_b);
    end
  end

  task automatic hold(input int i, input logic v, input int n);
    if (i == 0) rx_a = v; else rx_b = v;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // One frame; the outcome is pushed to the model before it is driven
  task automatic send(input int i, input logic [7:0] w, input bit badpar, input logic stopv);
    ev_t    e;
    int     c, nb;
    longint center;
    c = cpb(i);
    nb = (i == 1) ? 10 : 9;
    center = cyc + longint'(nb * c + c / 2);
    e.kind = (stopv == 1'b0) ? 1 : ((i == 1 && badpar) ? 2 : 0);
    e.word = w;
    e.tmin = center + 1;
    e.tmax = center + 5;
    if (i == 0) q0.push_back(e); else q1.push_back(e);
    hold(i, 1'b0, c);
    for (int b = 0; b < 8; b++) hold(i, w[b], c);
    if (i == 1) hold(i, (^w) ^ badpar, c);
    hold(i, stopv, c);
  endtask

  initial begin
    logic [7:0] w;
    logic [7:0] cmds [4];
    int         gap;
    bit         bp;
    logic       sv;
    cmds[0] = 8'h77; cmds[1] = 8'h61; cmds[2] = 8'h73; cmds[3] = 8'h64;
    for (int i = 0; i < 2; i++) begin
      exp_dat[i] = 8'h00; exp_led[i] = 4'b0000;
      cnt_v[i] = 0; cnt_f[i] = 0; cnt_p[i] = 0; last_v[i] = 0; prev_v[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    chk_en = 1'b1;
    chk("reset_led_a", led_a, 4'b0000);
    chk("reset_dout_a", dout_a, 8'h00);
    chk("reset_flags_a", {dv_a, fe_a, pe_a}, 3'b000);
    chk("reset_flags_b", {dv_b, fe_b, pe_b}, 3'b000);

    // Instance A: default 8N1 timing
    hold(0, 1'b1, 868);
    send(0, 8'h77, 1'b0, 1'b1);
    hold(0, 1'b1, 434);
    chk("w_valid_count", cnt_v[0], 1);
    chk("w_led", led_a, 4'b1000);
    chk("w_dout", dout_a, 8'h77);
    send(0, 8'h73, 1'b0, 1'b1);
    hold(0, 1'b1, 434);
    chk("s_led", led_a, 4'b0010);

    hold(0, 1'b0, 100);
    hold(0, 1'b1, 868);
    chk("glitch_no_pulse", cnt_v[0] + cnt_f[0] + cnt_p[0], 2);
    chk("glitch_led", led_a, 4'b0010);

    send(0, 8'h61, 1'b0, 1'b0);
    hold(0, 1'b1, 868);
    chk("ferr_count", cnt_f[0], 1);
    chk("ferr_led_kept", led_a, 4'b0010);
    chk("ferr_dout_kept", dout_a, 8'h73);

    send(0, 8'h61, 1'b0, 1'b1);
    chk("b2b_first_led", led_a, 4'b0100);
    send(0, 8'h64, 1'b0, 1'b1);
    hold(0, 1'b1, 868);
    chk("b2b_gap", last_v[0] - prev_v[0], 4340);
    chk("b2b_second_led", led_a, 4'b0001);
    chk("a_parity_never", cnt_p[0], 0);

    // Instance B: even parity, 16 clk/bit
    hold(1, 1'b1, 32);
    send(1, 8'h64, 1'b1, 1'b1);
    hold(1, 1'b1, 16);
    chk("perr_count", cnt_p[1], 1);
    chk("perr_led_kept", led_b, 4'b0000);
    send(1, 8'h64, 1'b0, 1'b1);
    hold(1, 1'b1, 16);
    chk("par_ok_led", led_b, 4'b0001);

    send(1, 8'h73, 1'b1, 1'b0);
    hold(1, 1'b0, 48);
    hold(1, 1'b1, 16);
    chk("ferr_over_perr", cnt_f[1], 1);
    send(1, 8'h77, 1'b0, 1'b1);
    hold(1, 1'b1, 16);
    chk("break_then_w_led", led_b, 4'b1000);

    // Reset during data bit 4 of an 'a' frame
    w = 8'h61;
    hold(1, 1'b0, 16);
    for (int b = 0; b < 4; b++) hold(1, w[b], 16);
    hold(1, w[4], 5);
    rst_b = 1'b1;
    @(posedge clk); #1;
    exp_led[1] = 4'b0000;
    exp_dat[1] = 8'h00;
    rx_b = 1'b1;
    chk("rst_led", led_b, 4'b0000);
    chk("rst_dout", dout_b, 8'h00);
    chk("rst_flags", {dv_b, fe_b, pe_b}, 3'b000);
    rst_b = 1'b0;
    hold(1, 1'b1, 200);
    chk("rst_no_pulse", cnt_v[1] + cnt_f[1] + cnt_p[1], 4);
    send(1, 8'h77, 1'b0, 1'b1);
    hold(1, 1'b1, 16);
    chk("rst_then_w_led", led_b, 4'b1000);

    // Randomized frames on B
    for (int n = 0; n < 120; n++) begin
      if ($urandom_range(1, 0) == 0) w = cmds[$urandom_range(3, 0)];
      else w = 8'($urandom_range(255, 0));
      bp = ($urandom_range(99, 0) < 15);
      sv = ($urandom_range(99, 0) < 10) ? 1'b0 : 1'b1;
      send(1, w, bp, sv);
      if (sv == 1'b0) gap = 16 + int'($urandom_range(40, 0));
      else if ($urandom_range(99, 0) < 30) gap = 0;
      else gap = int'($urandom_range(40, 1));
      if (gap > 0) hold(1, 1'b1, gap);
    end
    hold(1, 1'b1, 64);

    chk("queue_a_drained", q0.size(), 0);
    chk("queue_b_drained", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
